// File: rtl/sub86_mem_seq.sv
// Single-memory sequencer: arbitrates one synchronous 32-bit memory between
// core instruction fetch, core data access and a DMA port, then clock-enables the core.
module sub86_mem_seq #(
    parameter int WS = 1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] IA,
    output logic [15:0] ID,
    input  logic [31:0] A,
    input  logic [31:0] Q,
    input  logic        DWRN,
    input  logic        DRD,
    input  logic [1:0]  BEN,
    output logic [31:0] D,
    output logic        CE,
    input  logic        HALT,
    input  logic        DREQ,
    input  logic [31:0] DADR,
    input  logic [31:0] DWD,
    input  logic        DWE,
    input  logic [3:0]  DBE,
    output logic        DGNT,
    output logic [31:0] DRDATA,
    output logic        MCS,
    output logic        MWEN,
    output logic [31:0] MA,
    output logic [31:0] MWD,
    output logic [3:0]  MBE,
    input  logic [31:0] MRD,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DATA  = 3'd2,
        S_EXEC  = 3'd3,
        S_DMA   = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WS);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic        last_dma;
    logic [3:0]  data_mbe;
    logic [31:0] data_mwd;
    logic        data_req;
    logic        acc_done;
    logic        go_dma;
    logic        go_fetch;
    logic        unused_bits;

    assign unused_bits = ^{IA[0], DADR[1:0]};
    assign dbg_state   = state;
    assign data_req    = DRD | ~DWRN;
    assign acc_done    = (wait_cnt == 3'd0);

    // A pending DMA goes first only if the core had the last grant, or the core is halted.
    assign go_dma   = DREQ & (~last_dma | HALT);
    assign go_fetch = ~HALT & ~go_dma;

    always_comb begin
        data_mbe = 4'b1111;
        data_mwd = Q;
        case (BEN)
            2'b00: begin
                data_mbe = 4'b0001 << A[1:0];
                data_mwd = {4{Q[7:0]}};
            end
            2'b01: begin
                data_mbe = A[1] ? 4'b1100 : 4'b0011;
                data_mwd = {2{Q[15:0]}};
            end
            default: begin
                data_mbe = 4'b1111;
                data_mwd = Q;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            last_dma <= 1'b1;
            CE       <= 1'b0;
            DGNT     <= 1'b0;
            ID       <= 16'h0000;
            D        <= 32'h0;
            DRDATA   <= 32'h0;
            MCS      <= 1'b0;
            MWEN     <= 1'b1;
            MBE      <= 4'b0000;
            MA       <= 32'h0;
            MWD      <= 32'h0;
        end else begin
            CE   <= 1'b0;
            DGNT <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The DMA bus fields are captured here and held for the whole access.
                    if (go_dma) begin
                        state    <= S_DMA;
                        MCS      <= 1'b1;
                        MA       <= {DADR[31:2], 2'b00};
                        MWEN     <= ~DWE;
                        MBE      <= DBE;
                        MWD      <= DWD;
                        wait_cnt <= WAIT_LOAD;
                    end else if (go_fetch) begin
                        state    <= S_FETCH;
                        MCS      <= 1'b1;
                        MA       <= {IA[31:2], 2'b00};
                        MWEN     <= 1'b1;
                        MBE      <= 4'b1111;
                        wait_cnt <= WAIT_LOAD;
                        last_dma <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (acc_done) begin
                        ID <= IA[1] ? MRD[31:16] : MRD[15:0];
                        if (data_req) begin
                            state    <= S_DATA;
                            MA       <= {A[31:2], 2'b00};
                            MWEN     <= DWRN;
                            MBE      <= data_mbe;
                            MWD      <= data_mwd;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= S_EXEC;
                            CE    <= 1'b1;
                            MCS   <= 1'b0;
                            MWEN  <= 1'b1;
                            MBE   <= 4'b0000;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_DATA: begin
                    if (acc_done) begin
                        // MWEN high means this was a read; a write leaves D untouched.
                        if (MWEN) D <= MRD;
                        state <= S_EXEC;
                        CE    <= 1'b1;
                        MCS   <= 1'b0;
                        MWEN  <= 1'b1;
                        MBE   <= 4'b0000;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_EXEC: begin
                    state <= S_IDLE;
                end
                S_DMA: begin
                    if (acc_done) begin
                        if (MWEN) DRDATA <= MRD;
                        DGNT     <= 1'b1;
                        last_dma <= 1'b1;
                        state    <= S_IDLE;
                        MCS      <= 1'b0;
                        MWEN     <= 1'b1;
                        MBE      <= 4'b0000;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub86_mem_seq.sv
// Directed bench for sub86_mem_seq: core steps and DMA grants are scored against
// expected queues as the DUT pulses CE and DGNT.
module tb_sub86_mem_seq;

    localparam int WS_TB = 2;
    localparam int AC    = WS_TB + 1;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_DMA   = 3'd4;

    logic        CLK;
    logic        RSTN;
    logic [31:0] IA;
    logic [15:0] ID;
    logic [31:0] A;
    logic [31:0] Q;
    logic        DWRN;
    logic        DRD;
    logic [1:0]  BEN;
    logic [31:0] D;
    logic        CE;
    logic        HALT;
    logic        DREQ;
    logic [31:0] DADR;
    logic [31:0] DWD;
    logic        DWE;
    logic [3:0]  DBE;
    logic        DGNT;
    logic [31:0] DRDATA;
    logic        MCS;
    logic        MWEN;
    logic [31:0] MA;
    logic [31:0] MWD;
    logic [3:0]  MBE;
    logic [31:0] MRD;
    logic [2:0]  dbg_state;

    logic [31:0] mrd_val;
    logic [47:0] exp_q[$];
    logic [31:0] exp_dma_q[$];
    int          chk_cnt;
    int          pass_cnt;
    logic        prev_dgnt;

    // Memory stand-in: the DMA window at 0x400 returns a fixed pattern.
    assign MRD = (MA[31:8] == 24'h000004) ? 32'h5555_AAAA : mrd_val;

    sub86_mem_seq #(.WS(WS_TB)) u_dut (
        .CLK(CLK), .RSTN(RSTN), .IA(IA), .ID(ID), .A(A), .Q(Q), .DWRN(DWRN),
        .DRD(DRD), .BEN(BEN), .D(D), .CE(CE), .HALT(HALT), .DREQ(DREQ),
        .DADR(DADR), .DWD(DWD), .DWE(DWE), .DBE(DBE), .DGNT(DGNT),
        .DRDATA(DRDATA), .MCS(MCS), .MWEN(MWEN), .MA(MA), .MWD(MWD),
        .MBE(MBE), .MRD(MRD), .dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        int n;
        n = 0;
        while (dbg_state !== st && n < 100) begin
            step(1);
            n++;
        end
        check(tag, {61'd0, dbg_state}, {61'd0, st});
    endtask

    // Runs until CE, then parks the core with HALT so the next step is explicit.
    task automatic run_until_ce(input string tag, output int k, output int mcs_cnt);
        k = 0;
        mcs_cnt = 0;
        while (k < 100) begin
            step(1);
            k++;
            if (MCS === 1'b1) mcs_cnt++;
            if (CE === 1'b1) break;
        end
        check(tag, {63'd0, CE}, 64'd1);
        HALT = 1'b1;
    endtask

    // Scoreboard: each CE pops a core result, each DGNT pops a DMA result.
    always @(negedge CLK) begin
        if (RSTN === 1'b1) begin
            if (CE === 1'b1) begin
                check("ce_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) check("core_id_d", {16'd0, ID, D}, {16'd0, exp_q.pop_front()});
            end
            if (DGNT === 1'b1) begin
                check("dgnt_single", {63'd0, prev_dgnt}, 64'd0);
                check("dgnt_expected", {63'd0, exp_dma_q.size() != 0}, 64'd1);
                if (exp_dma_q.size() != 0) check("drdata", {32'd0, DRDATA}, {32'd0, exp_dma_q.pop_front()});
            end
        end
        prev_dgnt = DGNT;
    end

    initial begin
        int k;
        int mc;
        int n;
        int ce_cnt;
        logic fetch_seen;
        logic [3:0] ev;

        chk_cnt = 0; pass_cnt = 0; prev_dgnt = 1'b0;
        RSTN = 1'b1; IA = 32'h0; A = 32'h0; Q = 32'h0; DWRN = 1'b1; DRD = 1'b0;
        BEN = 2'b10; HALT = 1'b1; DREQ = 1'b0; DADR = 32'h0; DWD = 32'h0;
        DWE = 1'b0; DBE = 4'h0; mrd_val = 32'h1234_ABCD;
        #1 RSTN = 1'b0;
        step(2);

        check("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
        check("rst_ce_mcs_dgnt", {61'd0, CE, MCS, DGNT}, 64'd0);
        check("rst_mwen_mbe", {59'd0, MWEN, MBE}, {59'd0, 1'b1, 4'b0000});
        check("rst_id_d", {16'd0, ID, D}, 64'd0);
        check("rst_drdata", {32'd0, DRDATA}, 64'd0);

        // Fetch only, low halfword
        IA = 32'h0002_0000; HALT = 1'b0;
        exp_q.push_back({16'hABCD, 32'h0});
        RSTN = 1'b1;
        step(1);
        check("fetch_bus", {27'd0, MCS, MWEN, MBE, MA}, {27'd0, 1'b1, 1'b1, 4'hF, 32'h0002_0000});
        run_until_ce("fetch_ce", k, mc);
        check("fetch_ce_latency", k + 1, WS_TB + 2);
        check("fetch_mcs_cycles", mc + 1, AC);
        step(2);

        // Fetch only, high halfword
        IA = 32'h0002_0002; HALT = 1'b0;
        exp_q.push_back({16'h1234, 32'h0});
        run_until_ce("fetch_hi_ce", k, mc);
        check("fetch_hi_latency", k, WS_TB + 2);
        step(2);

        // Byte write at offset 3 with a simultaneous read request: write wins
        DWRN = 1'b0; DRD = 1'b1; A = 32'h0000_0103; BEN = 2'b00; Q = 32'h0000_00EE;
        HALT = 1'b0;
        exp_q.push_back({16'h1234, 32'h0});
        wait_state(ST_DATA, "byte_wr_data");
        check("byte_wr_bus", {27'd0, MCS, MWEN, MBE, MA}, {27'd0, 1'b1, 1'b0, 4'b1000, 32'h100});
        check("byte_wr_lane3", {56'd0, MWD[31:24]}, 64'hEE);
        run_until_ce("byte_wr_ce", k, mc);
        check("byte_wr_ce_after", k, AC);
        step(2);

        // Read with waits: total step FETCH + DATA + EXEC
        DWRN = 1'b1; DRD = 1'b1; A = 32'h0000_0200; BEN = 2'b10; IA = 32'h0002_0000;
        mrd_val = 32'hCAFE_F00D; HALT = 1'b0;
        exp_q.push_back({16'hF00D, 32'hCAFE_F00D});
        run_until_ce("rd_ce", k, mc);
        check("rd_step_cycles", k, 2 * AC + 1);
        check("rd_mcs_cycles", mc, 2 * AC);
        step(1);
        check("rd_d_stable", {32'd0, D}, {32'd0, 32'hCAFE_F00D});
        step(1);

        // DREQ held with HALT low: grants alternate
        DRD = 1'b0; DREQ = 1'b1; DADR = 32'h0000_0400; DWE = 1'b0; DBE = 4'hF;
        HALT = 1'b0;
        exp_q.push_back({16'hF00D, 32'hCAFE_F00D});
        exp_q.push_back({16'hF00D, 32'hCAFE_F00D});
        exp_dma_q.push_back(32'h5555_AAAA);
        exp_dma_q.push_back(32'h5555_AAAA);
        ev = 4'b0000; n = 0; k = 0;
        while (n < 4 && k < 200) begin
            step(1);
            k++;
            if (DGNT === 1'b1) begin ev[3 - n] = 1'b1; n++; end
            else if (CE === 1'b1) begin ev[3 - n] = 1'b0; n++; end
        end
        HALT = 1'b1; DREQ = 1'b0;
        check("rr_events", n, 4);
        check("rr_order", {60'd0, ev}, {60'd0, 4'b1010});
        step(3);

        // DMA write with HALT: fields captured at entry, DREQ dropped mid-access
        DREQ = 1'b1; DADR = 32'h0000_040F; DWE = 1'b1; DWD = 32'h1122_3344; DBE = 4'b0011;
        exp_dma_q.push_back(32'h5555_AAAA);
        wait_state(ST_DMA, "dma_wr_enter");
        DREQ = 1'b0; DADR = 32'hFFFF_FFFF; DWE = 1'b0; DWD = 32'h0; DBE = 4'h0;
        step(1);
        check("dma_wr_bus", {27'd0, MCS, MWEN, MBE, MA}, {27'd0, 1'b1, 1'b0, 4'b0011, 32'h40C});
        check("dma_wr_data", {32'd0, MWD}, {32'd0, 32'h1122_3344});
        k = 0;
        while (DGNT !== 1'b1 && k < 50) begin step(1); k++; end
        check("dma_wr_dgnt", {63'd0, DGNT}, 64'd1);
        step(2);
        check("dma_wr_idle", {61'd0, dbg_state}, {61'd0, ST_IDLE});

        // Halfword write; HALT raised during DATA, then a DMA read is served
        DWRN = 1'b0; BEN = 2'b01; A = 32'h0000_0006; Q = 32'h0000_BEEF; HALT = 1'b0;
        exp_q.push_back({16'hF00D, 32'hCAFE_F00D});
        wait_state(ST_DATA, "halt_data");
        check("half_wr_bus", {27'd0, MWEN, MBE, MA}, {27'd0, 1'b0, 4'b1100, 32'h4});
        check("half_wr_data", {32'd0, MWD}, {32'd0, 32'hBEEF_BEEF});
        HALT = 1'b1; DREQ = 1'b1; DADR = 32'h0000_0400; DWE = 1'b0; DBE = 4'hF;
        exp_dma_q.push_back(32'h5555_AAAA);
        ce_cnt = 0; fetch_seen = 1'b0; k = 0;
        while (k < 60) begin
            step(1);
            k++;
            if (CE === 1'b1) ce_cnt++;
            if (dbg_state === ST_FETCH) fetch_seen = 1'b1;
            if (DGNT === 1'b1) break;
        end
        DREQ = 1'b0; DWRN = 1'b1;
        check("halt_dgnt", {63'd0, DGNT}, 64'd1);
        check("halt_ce_once", ce_cnt, 1);
        check("halt_no_fetch", {63'd0, fetch_seen}, 64'd0);
        step(2);

        // Reset during the second cycle of a DMA write
        DREQ = 1'b1; DADR = 32'h0000_0500; DWE = 1'b1; DWD = 32'hDEAD_BEEF; DBE = 4'hF;
        wait_state(ST_DMA, "rst_dma_enter");
        step(1);
        RSTN = 1'b0;
        #1;
        check("rst_mid_mcs", {61'd0, MCS, DGNT, CE}, 64'd0);
        check("rst_mid_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
        check("rst_mid_outs", {16'd0, ID, D}, 64'd0);
        check("rst_mid_drdata", {32'd0, DRDATA}, 64'd0);
        step(1);
        DRD = 1'b0; DWRN = 1'b1; IA = 32'h0002_0000; HALT = 1'b0;
        exp_q.push_back({16'hF00D, 32'h0});
        RSTN = 1'b1;
        k = 0;
        while (MCS !== 1'b1 && k < 20) begin step(1); k++; end
        check("post_rst_first", {29'd0, dbg_state, MA}, {29'd0, ST_FETCH, 32'h0002_0000});
        DREQ = 1'b0;
        run_until_ce("post_rst_ce", k, mc);
        step(3);

        check("core_q_empty", exp_q.size(), 0);
        check("dma_q_empty", exp_dma_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
